// File: rtl/free_list.sv
// free_list
//   Circular FIFO of free physical-register tags. It supplies up to two free
//   tags per cycle to rename/dispatch and takes back up to two tags per cycle
//   that the re-order buffer frees at retirement.
//
//   Ports:
//     clock              rising-edge clock
//     reset              synchronous, active-high; reloads tags ARCH_COUNT..
//     id_dispatch_num    tags consumed this cycle (3 behaves as 2)
//     rob_retire_num     retired tags offered this cycle (3 behaves as 2)
//     rob_retire_tag_a   first retired tag, valid when rob_retire_num >= 1
//     rob_retire_tag_b   second retired tag, valid when rob_retire_num == 2
//     fl_pr0             tag at head, NULL_TAG when the list is empty
//     fl_pr1             tag at head+1, NULL_TAG when fewer than two are held
//     fl_cap             min(count, 2)
//     fl_count           number of free tags held
//     fl_empty           count == 0
//     fl_error           sticky underflow/overflow flag, cleared by reset
//
//   All outputs are decoded from registered state only; a tag pushed in one
//   cycle is first visible on fl_pr* in the following cycle.
module free_list #(
    parameter int                  PR_TAG_W   = 7,
    parameter int                  ARCH_COUNT = 32,
    parameter int                  DEPTH      = 95,
    parameter logic [PR_TAG_W-1:0] NULL_TAG   = 7'h7f
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          id_dispatch_num,
    input  logic [1:0]          rob_retire_num,
    input  logic [PR_TAG_W-1:0] rob_retire_tag_a,
    input  logic [PR_TAG_W-1:0] rob_retire_tag_b,
    output logic [PR_TAG_W-1:0] fl_pr0,
    output logic [PR_TAG_W-1:0] fl_pr1,
    output logic [1:0]          fl_cap,
    output logic [PR_TAG_W-1:0] fl_count,
    output logic                fl_empty,
    output logic                fl_error
);

    localparam logic [PR_TAG_W-1:0] DEPTH_T = PR_TAG_W'(DEPTH);
    localparam logic [PR_TAG_W-1:0] TWO_T   = PR_TAG_W'(2);

    // Registered state
    logic [PR_TAG_W-1:0] entry [DEPTH];
    logic [PR_TAG_W-1:0] head;
    logic [PR_TAG_W-1:0] tail;
    logic [PR_TAG_W-1:0] count;
    logic                error;

    // Next-state terms
    logic [1:0]          disp_req;
    logic [1:0]          ret_req;
    logic                underflow;
    logic                overflow;
    logic [1:0]          pops;
    logic [1:0]          pushes;
    logic                keep_a;
    logic                keep_b;
    logic [PR_TAG_W-1:0] surv0;
    logic [PR_TAG_W-1:0] surv1;
    logic [1:0]          n_surv;
    logic [PR_TAG_W-1:0] remain;
    logic [PR_TAG_W-1:0] room;
    logic [PR_TAG_W-1:0] head_p1;
    logic [PR_TAG_W-1:0] head_next;
    logic [PR_TAG_W-1:0] tail_p1;
    logic [PR_TAG_W-1:0] tail_next;
    logic [PR_TAG_W-1:0] count_next;

    // Pointer advance with explicit wrap at DEPTH, which is not a power of two.
    function automatic logic [PR_TAG_W-1:0] ptr_add(input logic [PR_TAG_W-1:0] ptr,
                                                     input logic [1:0]          k);
        logic [PR_TAG_W:0] sum;
        sum = {1'b0, ptr} + {{(PR_TAG_W-1){1'b0}}, k};
        if (sum >= {1'b0, DEPTH_T}) begin
            sum = sum - {1'b0, DEPTH_T};
        end
        return sum[PR_TAG_W-1:0];
    endfunction

    always_comb begin
        disp_req = (id_dispatch_num == 2'd3) ? 2'd2 : id_dispatch_num;
        ret_req  = (rob_retire_num == 2'd3) ? 2'd2 : rob_retire_num;

        // Pop only what is actually held; asking for more is an error.
        underflow = PR_TAG_W'(disp_req) > count;
        pops      = underflow ? count[1:0] : disp_req;

        // Null tags are dropped silently; survivors are compacted so that a
        // lone surviving b still lands at tail.
        keep_a = (ret_req != 2'd0) && (rob_retire_tag_a != NULL_TAG);
        keep_b = (ret_req == 2'd2) && (rob_retire_tag_b != NULL_TAG);
        surv0  = keep_a ? rob_retire_tag_a : rob_retire_tag_b;
        surv1  = rob_retire_tag_b;
        n_surv = {1'b0, keep_a} + {1'b0, keep_b};

        // Room is measured after this cycle's pops. When room runs short the
        // later survivor (b) is the one discarded.
        remain   = count - PR_TAG_W'(pops);
        room     = DEPTH_T - remain;
        overflow = PR_TAG_W'(n_surv) > room;
        pushes   = overflow ? room[1:0] : n_surv;

        head_p1    = ptr_add(head, 2'd1);
        head_next  = ptr_add(head, pops);
        tail_p1    = ptr_add(tail, 2'd1);
        tail_next  = ptr_add(tail, pushes);
        count_next = remain + PR_TAG_W'(pushes);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= PR_TAG_W'(ARCH_COUNT + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= DEPTH_T;
            error <= 1'b0;
        end else begin
            if (pushes != 2'd0) begin
                entry[tail] <= surv0;
            end
            if (pushes == 2'd2) begin
                entry[tail_p1] <= surv1;
            end
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            error <= error | underflow | overflow;
        end
    end

    assign fl_pr0   = (count != '0)    ? entry[head]    : NULL_TAG;
    assign fl_pr1   = (count >= TWO_T) ? entry[head_p1] : NULL_TAG;
    assign fl_cap   = (count >= TWO_T) ? 2'd2 : count[1:0];
    assign fl_count = count;
    assign fl_empty = (count == '0);
    assign fl_error = error;

endmodule

// File: tb/tb_free_list.sv
// tb_free_list
//   Directed bench for free_list. Stimulus applies one vector per clock and
//   queues the outputs it expects afterwards; a monitor on the falling edge
//   pops each expectation and compares it with the DUT outputs.
module tb_free_list;

    localparam int NULL_T = 127;

    logic       clock;
    logic       reset;
    logic [1:0] id_dispatch_num;
    logic [1:0] rob_retire_num;
    logic [6:0] rob_retire_tag_a;
    logic [6:0] rob_retire_tag_b;
    logic [6:0] fl_pr0;
    logic [6:0] fl_pr1;
    logic [1:0] fl_cap;
    logic [6:0] fl_count;
    logic       fl_empty;
    logic       fl_error;

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .id_dispatch_num  (id_dispatch_num),
        .rob_retire_num   (rob_retire_num),
        .rob_retire_tag_a (rob_retire_tag_a),
        .rob_retire_tag_b (rob_retire_tag_b),
        .fl_pr0           (fl_pr0),
        .fl_pr1           (fl_pr1),
        .fl_cap           (fl_cap),
        .fl_count         (fl_count),
        .fl_empty         (fl_empty),
        .fl_error         (fl_error)
    );

    typedef struct {
        string      name;
        logic [6:0] pr0;
        logic [6:0] pr1;
        logic [1:0] cap;
        logic [6:0] cnt;
        logic       empty;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   stim_done = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs after the most recent edge; cap and empty follow
    // directly from the expected count.
    task automatic expect_st(input string name, input int pr0, input int pr1,
                             input int cnt, input int err);
        exp_t e;
        e.name  = name;
        e.pr0   = 7'(pr0);
        e.pr1   = 7'(pr1);
        e.cnt   = 7'(cnt);
        e.cap   = (cnt >= 2) ? 2'd2 : 2'(cnt);
        e.empty = (cnt == 0);
        e.err   = (err != 0);
        q.push_back(e);
    endtask

    task automatic step(input int rst_v, input int disp, input int rn,
                        input int a, input int b);
        reset            = (rst_v != 0);
        id_dispatch_num  = 2'(disp);
        rob_retire_num   = 2'(rn);
        rob_retire_tag_a = 7'(a);
        rob_retire_tag_b = 7'(b);
        @(posedge clock);
        #1;
    endtask

    function automatic int tag_if(input int cnt, input int need, input int v);
        return (cnt >= need) ? v : NULL_T;
    endfunction

    // Order of tags in the list after a full-list pop-2/push-(40,41) cycle.
    function automatic int full_list(input int i);
        if (i < 93) return 34 + i;
        if (i == 93) return 40;
        return 41;
    endfunction

    // Monitor: compares the oldest expectation against the outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (fl_pr0 !== e.pr0 || fl_pr1 !== e.pr1 || fl_cap !== e.cap ||
                    fl_count !== e.cnt || fl_empty !== e.empty || fl_error !== e.err) begin
                    n_bad++;
                    $display("FAIL %s: got pr0=%0d pr1=%0d cap=%0d count=%0d empty=%0d error=%0d; want pr0=%0d pr1=%0d cap=%0d count=%0d empty=%0d error=%0d",
                             e.name, fl_pr0, fl_pr1, fl_cap, fl_count, fl_empty, fl_error,
                             e.pr0, e.pr1, e.cap, e.cnt, e.empty, e.err);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int cnt;
        reset            = 1'b1;
        id_dispatch_num  = 2'd0;
        rob_retire_num   = 2'd0;
        rob_retire_tag_a = 7'd0;
        rob_retire_tag_b = 7'd0;

        // Reset and idle
        step(1, 0, 0, 0, 0);
        expect_st("reset", 32, 33, 95, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            expect_st("idle", 32, 33, 95, 0);
        end

        // Drain by two; the last tag 126 is left alone, then underflow
        for (int k = 1; k <= 47; k++) begin
            step(0, 2, 0, 0, 0);
            cnt = 95 - 2 * k;
            expect_st("drain2", tag_if(cnt, 1, 32 + 2 * k), tag_if(cnt, 2, 33 + 2 * k), cnt, 0);
        end
        step(0, 2, 0, 0, 0);
        expect_st("underflow", NULL_T, NULL_T, 0, 1);

        // Drain by one from a fresh reset; head wraps 94 -> 0
        step(1, 0, 0, 0, 0);
        expect_st("reset2", 32, 33, 95, 0);
        for (int k = 1; k <= 95; k++) begin
            step(0, 1, 0, 0, 0);
            cnt = 95 - k;
            expect_st("drain1", tag_if(cnt, 1, 32 + k), tag_if(cnt, 2, 33 + k), cnt, 0);
        end

        // Refill; not visible until the cycle after the push
        step(0, 0, 2, 5, 6);
        expect_st("refill_a", 5, 6, 2, 0);
        step(0, 0, 2, 7, 8);
        expect_st("refill_b", 5, 6, 4, 0);
        for (int j = 1; j <= 45; j++) begin
            step(0, 0, 2, 7 + 2 * j, 8 + 2 * j);
            expect_st("refill_n", 5, 6, 4 + 2 * j, 0);
        end
        // tail is at 94: this pair lands at entries 94 and 0
        step(0, 2, 2, 99, 100);
        expect_st("tail_wrap", 7, 8, 94, 0);
        for (int k = 1; k <= 47; k++) begin
            step(0, 2, 0, 0, 0);
            cnt = 94 - 2 * k;
            expect_st("wrap_order", tag_if(cnt, 1, 7 + 2 * k), tag_if(cnt, 2, 8 + 2 * k), cnt, 0);
        end

        // Null and partial retire
        step(0, 0, 2, 9, NULL_T);
        expect_st("null_b", 9, NULL_T, 1, 0);
        step(0, 0, 1, 10, 11);
        expect_st("partial_1", 9, 10, 2, 0);
        step(0, 3, 0, 0, 0);
        expect_st("disp3_as_2", NULL_T, NULL_T, 0, 0);
        // Pop request at empty plus a push: error, push still lands
        step(0, 1, 1, 20, 0);
        expect_st("pop_push_empty", 20, NULL_T, 1, 1);

        // Full list with pop 2 / push 2
        step(1, 0, 0, 0, 0);
        expect_st("reset3", 32, 33, 95, 0);
        step(0, 2, 2, 40, 41);
        expect_st("full_swap", 34, 35, 95, 0);
        for (int k = 1; k <= 93; k++) begin
            step(0, 1, 0, 0, 0);
            expect_st("full_order", full_list(k), full_list(k + 1), 95 - k, 0);
        end

        // Overflow at full
        step(1, 0, 0, 0, 0);
        expect_st("reset4", 32, 33, 95, 0);
        step(0, 0, 1, 50, 0);
        expect_st("overflow", 32, 33, 95, 1);

        // Mid-stream reset restores everything, including the error flag
        for (int i = 0; i < 10; i++) begin
            step(0, i % 3, (i + 1) % 3, 60 + i, 70 + i);
        end
        step(1, 2, 2, 1, 2);
        expect_st("reset_mid", 32, 33, 95, 0);
        step(0, 0, 0, 0, 0);
        expect_st("post_reset_idle", 32, 33, 95, 0);

        stim_done = 1;
    end

    // Completion: bounded wait for the queue to drain, then summary.
    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && q.size() == 0) && budget < 5000) begin
            @(negedge clock);
            budget++;
        end
        if (!(stim_done && q.size() == 0)) begin
            n_bad++;
            $display("FAIL timeout: got %0d pending expectations, want 0", q.size());
        end
        @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical-register tags feeding rename/dispatch; the return path for tags the re-order buffer frees at retirement. Each cycle it presents up to two free tags (`fl_pr0`, `fl_pr1`) plus a capacity count to dispatch. It pops the number of tags dispatch consumes and pushes up to two retired tags from the ROB. Tag 7'h7f is the null tag: it is never allocated and is ignored on the retire path.

## Interface
- `PR_TAG_W`, default 7: physical tag width.
- `ARCH_COUNT`, default 32: tags 0..31 are architecturally mapped at reset and never in the list initially.
- `DEPTH`, default 95: list capacity; holds tags ARCH_COUNT..126.
- `NULL_TAG`, default 7'h7f: invalid/empty tag value.

Ports:
- `clock` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `id_dispatch_num` input 2: tags consumed this cycle; 3 is treated as 2.
- `rob_retire_num` input 2: retired tags offered; 3 is treated as 2.
- `rob_retire_tag_a` input 7: first retired tag; valid when `rob_retire_num`≥1.
- `rob_retire_tag_b` input 7: second retired tag; valid when `rob_retire_num`=2.
- `fl_pr0` output 7: tag at head; NULL_TAG if count=0.
- `fl_pr1` output 7: tag at head+1; NULL_TAG if count<2.
- `fl_cap` output 2: min(count,2).
- `fl_count` output 7: number of free tags held.
- `fl_empty` output 1: count==0.
- `fl_error` output 1: sticky; set on underflow or overflow attempt; cleared only by reset.

## Operation
- State: `entry[0..DEPTH-1]` (7 bits each), `head`, `tail` (7 bits, range 0..DEPTH-1), `count` (0..DEPTH), `error`.
- Reset contents:
  - `entry[i]` = ARCH_COUNT+i; `head`=0, `tail`=0, `count`=DEPTH, `error`=0.
  - Resulting outputs: `fl_pr0`=32, `fl_pr1`=33, `fl_cap`=2, `fl_count`=95, `fl_empty`=0, `fl_error`=0.
- Pop:
  - pops = min(`id_dispatch_num` clamped to 2, count).
  - If the request exceeds count, set `error`; only pops tags are removed.
  - `head` advances by pops.
- Push:
  - Candidate list is a then b, limited by `rob_retire_num`. Candidates equal to NULL_TAG are dropped silently (no error).
  - Survivors are written in order at `tail`, `tail`+1.
  - pushes = survivors accepted. If count−pops+survivors > DEPTH, excess survivors (b first) are dropped and `error` is set.
  - `tail` advances by pushes.
- Pointer wrap: ptr+k ≥ DEPTH ⇒ ptr+k−DEPTH. Never rely on power-of-two wrap.
- `count_next` = count − pops + pushes. Overflow is evaluated after same-cycle pops, so popping frees room for a same-cycle push.
- No duplicate-tag detection; pushing a tag already present is the ROB's responsibility.

## Timing
- `fl_pr0`, `fl_pr1`, `fl_cap`, `fl_count`, `fl_empty`, `fl_error` are combinational from registered state only. There is no combinational path from any input to any output.
- Pops and pushes take effect at the next rising edge.
- Retired tags are not bypassed: a tag pushed in cycle N is first visible on `fl_pr*` in cycle N+1.
- Simultaneous pop and push at count=0:
  - Pop request sets `error` and pops nothing.
  - Pushes still land, so next cycle `fl_pr0`=`rob_retire_tag_a`.
- Simultaneous at count=DEPTH with pops=2 and pushes=2: count stays DEPTH, no error.
- Reset mid-operation restores full reset contents at the next edge. Inputs are ignored in the reset cycle.

## Test plan
- Reset:
  - Hold `reset` 1 cycle, then idle: `fl_pr0`=32, `fl_pr1`=33, `fl_cap`=2, `fl_count`=95, `fl_error`=0.
  - 5 idle cycles: outputs unchanged.
- Drain:
  - `id_dispatch_num`=2 for 47 cycles: tags 32..125 emitted in order; then `fl_count`=1, `fl_cap`=1, `fl_pr0`=126, `fl_pr1`=7'h7f.
  - One more cycle with 2: `fl_count`=0, `fl_empty`=1, `fl_error`=1.
- Refill and wrap:
  - After draining via dispatch=1 ×95 (error stays 0), retire pairs (5,6),(7,8) with dispatch=0: next cycles `fl_pr0`=5, `fl_pr1`=6, `fl_count`=4.
  - `tail` wraps from 94 to 0 correctly: checked via order of subsequently popped tags.
- Null and partial retire:
  - `rob_retire_num`=2, a=9, b=7'h7f: count +1, `fl_error` stays 0.
  - `rob_retire_num`=1, b=10: b ignored.
- Full with simultaneous traffic:
  - At count=95, dispatch=2 and retire (40,41): count stays 95, no error; 40 and 41 appear after the remaining 93 tags.
  - At count=95, dispatch=0 and retire=1: `fl_error`=1, count 95.
- Reset mid-stream: after 10 mixed cycles, assert `reset` together with dispatch=2: next cycle state equals the reset state exactly.
